// File: rtl/pc_redirect_unit_pkg.sv
// Shared CPU definitions for the PC redirect unit: widths, branch-unit decision
// codes, fetch FSM state encoding and the redirect decode helper.
package pc_redirect_unit_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEC_W    = 2;
    localparam int unsigned STATE_W  = 2;
    localparam int unsigned INSN_BYTES = 4;

    // Redirect code produced by the branching unit in EX.
    typedef enum logic [DEC_W-1:0] {
        DEC_NONE = 2'b00,
        DEC_REL  = 2'b01,
        DEC_REG  = 2'b10,
        DEC_RSVD = 2'b11
    } decision_e;

    // Fetch-side FSM state encoding.
    typedef enum logic [STATE_W-1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10
    } state_e;

    // Decoded redirect request travelling from the EX inputs into the FSM.
    typedef struct packed {
        logic            req;
        logic            misaligned;
        logic [XLEN-1:0] target;
    } redirect_t;

    // Resolve the EX redirect request: pick the target and flag any target that
    // is not word aligned (JALR targets have bit 0 cleared first, so only bit 1
    // can make them misaligned).
    function automatic redirect_t decode_redirect(
        input logic            ex_valid,
        input logic [DEC_W-1:0] decision,
        input logic [XLEN-1:0] target_rel,
        input logic [XLEN-1:0] target_reg
    );
        redirect_t r;
        r.req        = 1'b0;
        r.target     = target_rel;
        r.misaligned = 1'b0;
        if (ex_valid) begin
            case (decision_e'(decision))
                DEC_REL: begin
                    r.req    = 1'b1;
                    r.target = target_rel;
                end
                DEC_REG: begin
                    r.req    = 1'b1;
                    r.target = {target_reg[XLEN-1:1], 1'b0};
                end
                default: begin
                    r.req    = 1'b0;
                    r.target = target_rel;
                end
            endcase
        end
        r.misaligned = r.req && (r.target[1:0] != 2'b00);
        return r;
    endfunction

endpackage

// File: rtl/pc_redirect_unit.sv
// PC redirect unit: owns the fetch PC, sequences BOOT/RUN/TRAP, applies
// branch/jump redirects from EX with priority over stall and sequential
// advance, raises pipeline flushes and a misaligned-target trap pulse, and
// counts taken redirects.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   decision        EX redirect code (none / PC-relative / register / reserved)
//   ex_valid        qualifies decision
//   target_rel      PC+imm from EX
//   target_reg      rs1+imm from EX
//   stall           IF freeze from the hazard unit
//   fetch_valid     fetch request to instruction memory (combinational)
//   fetch_ready     instruction memory accepts the request
//   pc, pc_plus4    current fetch address and its sequential successor
//   flush_ifid      bubble IF/ID (combinational, same cycle as the redirect)
//   flush_idex      bubble ID/EX (combinational, same cycle as the redirect)
//   misaligned      one-cycle trap pulse for a misaligned redirect target
//   redirect_cnt    number of redirects taken (wraps)
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  decision,
    input  logic        ex_valid,
    input  logic [31:0] target_rel,
    input  logic [31:0] target_reg,
    input  logic        stall,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        misaligned,
    output logic [31:0] redirect_cnt
);

    state_e          state_q;
    state_e          state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] redirect_cnt_q;
    logic [XLEN-1:0] redirect_cnt_d;
    redirect_t       redir;
    logic            in_run;

    // Redirect request decode from the EX stage inputs.
    always_comb begin
        redir = decode_redirect(ex_valid, decision, target_rel, target_reg);
    end

    // Redirects only act while fetching; BOOT and TRAP ignore them.
    assign in_run = (state_q == ST_RUN);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (redir.req && redir.misaligned) begin
                    state_d = ST_TRAP;
                end
            end
            ST_TRAP: state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // FSM outputs: fetch request, flushes and trap pulse.
    always_comb begin
        fetch_valid = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        misaligned  = 1'b0;
        if (in_run) begin
            fetch_valid = 1'b1;
            if (redir.req) begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                misaligned = redir.misaligned;
            end
        end
    end

    // Next PC and redirect counter: redirect beats stall and sequential advance.
    always_comb begin
        pc_d           = pc_q;
        redirect_cnt_d = redirect_cnt_q;
        case (state_q)
            ST_BOOT: pc_d = RESET_PC;
            ST_RUN: begin
                if (redir.req) begin
                    if (redir.misaligned) begin
                        pc_d = TRAP_PC;
                    end else begin
                        pc_d           = redir.target;
                        redirect_cnt_d = redirect_cnt_q + XLEN'(1);
                    end
                end else if (!stall && fetch_ready) begin
                    pc_d = pc_q + XLEN'(INSN_BYTES);
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    // PC and redirect counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= RESET_PC;
            redirect_cnt_q <= '0;
        end else begin
            pc_q           <= pc_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign pc           = pc_q;
    assign pc_plus4     = pc_q + XLEN'(INSN_BYTES);
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: the driver applies one directed vector
// per cycle and queues the hand-computed outputs for that cycle; the monitor
// pops and compares on the following falling edge.
module tb_pc_redirect_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  decision;
    logic        ex_valid;
    logic [31:0] target_rel;
    logic [31:0] target_reg;
    logic        stall;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush_ifid;
    logic        flush_idex;
    logic        misaligned;
    logic [31:0] redirect_cnt;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   done     = 1'b0;

    pc_redirect_unit #(
        .RESET_PC(32'h0000_0000),
        .TRAP_PC (32'h0000_0100)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .decision    (decision),
        .ex_valid    (ex_valid),
        .target_rel  (target_rel),
        .target_reg  (target_reg),
        .stall       (stall),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .flush_ifid  (flush_ifid),
        .flush_idex  (flush_idex),
        .misaligned  (misaligned),
        .redirect_cnt(redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
        end
    endtask

    // Monitor: compare every cycle that has a queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, "pc",           pc,                   e.pc);
            check(e.name, "pc_plus4",     pc_plus4,             e.pc + 32'd4);
            check(e.name, "fetch_valid",  32'(fetch_valid),     32'(e.fv));
            check(e.name, "flush_ifid",   32'(flush_ifid),      32'(e.fl));
            check(e.name, "flush_idex",   32'(flush_idex),      32'(e.fl));
            check(e.name, "misaligned",   32'(misaligned),      32'(e.mis));
            check(e.name, "redirect_cnt", redirect_cnt,         e.cnt);
        end
    end

    // Apply one cycle of stimulus just after the rising edge and queue its expectation.
    task automatic step(input string nm, input logic r,
                        input logic [1:0] dec, input logic ev,
                        input logic [31:0] rel, input logic [31:0] rg,
                        input logic st, input logic rdy,
                        input logic [31:0] epc, input logic efv, input logic efl,
                        input logic emis, input logic [31:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n       = r;
        decision    = dec;
        ex_valid    = ev;
        target_rel  = rel;
        target_reg  = rg;
        stall       = st;
        fetch_ready = rdy;
        e.name = nm; e.pc = epc; e.fv = efv; e.fl = efl; e.mis = emis; e.cnt = ecnt;
        exp_q.push_back(e);
    endtask

    // Global time bound so the run always ends.
    initial begin
        #20000;
        if (!done) begin
            $display("FAIL timeout: run did not complete, %0d expectations pending", exp_q.size());
            $fatal(1, "timeout");
        end
    end

    initial begin
        exp_t e;
        rst_n = 1'b0; decision = 2'b00; ex_valid = 1'b0;
        target_rel = '0; target_reg = '0; stall = 1'b0; fetch_ready = 1'b1;

        //    name           rst dec    ev rel           reg           st rdy pc            fv fl mis cnt
        step("reset",        0, 2'b00, 0, 32'h0,       32'h0,        0, 1, 32'h0000_0000, 0, 0, 0, 32'd0);
        step("boot",         1, 2'b00, 0, 32'h0,       32'h0,        0, 1, 32'h0000_0000, 0, 0, 0, 32'd0);
        step("run_pc0",      1, 2'b00, 0, 32'h0,       32'h0,        0, 1, 32'h0000_0000, 1, 0, 0, 32'd0);
        step("run_pc4",      1, 2'b00, 0, 32'h0,       32'h0,        0, 1, 32'h0000_0004, 1, 0, 0, 32'd0);
        step("run_pc8",      1, 2'b00, 0, 32'h0,       32'h0,        0, 1, 32'h0000_0008, 1, 0, 0, 32'd0);
        step("run_pcc",      1, 2'b00, 0, 32'h0,       32'h0,        0, 1, 32'h0000_000C, 1, 0, 0, 32'd0);
        step("rel_redirect", 1, 2'b01, 1, 32'h40,      32'h0,        0, 1, 32'h0000_0010, 1, 1, 0, 32'd0);
        step("reg_stall",    1, 2'b10, 1, 32'h0,       32'h81,       1, 1, 32'h0000_0040, 1, 1, 0, 32'd1);
        step("stall_hold0",  1, 2'b00, 0, 32'h0,       32'h0,        1, 1, 32'h0000_0080, 1, 0, 0, 32'd2);
        step("stall_hold1",  1, 2'b00, 0, 32'h0,       32'h0,        1, 1, 32'h0000_0080, 1, 0, 0, 32'd2);
        step("unstall",      1, 2'b00, 0, 32'h0,       32'h0,        0, 1, 32'h0000_0080, 1, 0, 0, 32'd2);
        step("misalign",     1, 2'b01, 1, 32'h42,      32'h0,        0, 1, 32'h0000_0084, 1, 1, 1, 32'd2);
        step("trap_ignore",  1, 2'b01, 1, 32'h200,     32'h0,        0, 1, 32'h0000_0100, 0, 0, 0, 32'd2);
        step("notready0",    1, 2'b00, 0, 32'h0,       32'h0,        0, 0, 32'h0000_0100, 1, 0, 0, 32'd2);
        step("notready_rsv", 1, 2'b11, 1, 32'h300,     32'h300,      0, 0, 32'h0000_0100, 1, 0, 0, 32'd2);
        step("notready2",    1, 2'b00, 0, 32'h0,       32'h0,        0, 0, 32'h0000_0100, 1, 0, 0, 32'd2);
        step("exv_low",      1, 2'b01, 0, 32'h300,     32'h0,        0, 1, 32'h0000_0100, 1, 0, 0, 32'd2);

        // Counter preload: held across one edge so the register itself captures it.
        step("preload",      1, 2'b00, 0, 32'h0,       32'h0,        0, 1, 32'h0000_0104, 1, 0, 0, 32'hFFFF_FFFF);
        force dut.redirect_cnt_q = 32'hFFFF_FFFF;
        step("wrap_redir",   1, 2'b01, 1, 32'h200,     32'h0,        0, 1, 32'h0000_0108, 1, 1, 0, 32'hFFFF_FFFF);
        release dut.redirect_cnt_q;
        step("wrap_done",    1, 2'b00, 0, 32'h0,       32'h0,        0, 1, 32'h0000_0200, 1, 0, 0, 32'd0);

        // Reset asserted in the middle of a redirect cycle.
        @(posedge clk);
        #1;
        decision = 2'b01; ex_valid = 1'b1; target_rel = 32'h300;
        #2;
        rst_n = 1'b0;
        e.name = "reset_mid"; e.pc = 32'h0; e.fv = 1'b0; e.fl = 1'b0; e.mis = 1'b0; e.cnt = 32'd0;
        exp_q.push_back(e);

        step("reset_hold",   0, 2'b01, 1, 32'h300,     32'h0,        0, 1, 32'h0000_0000, 0, 0, 0, 32'd0);
        step("boot2",        1, 2'b01, 1, 32'h300,     32'h0,        0, 1, 32'h0000_0000, 0, 0, 0, 32'd0);
        step("run2_pc0",     1, 2'b00, 0, 32'h0,       32'h0,        0, 1, 32'h0000_0000, 1, 0, 0, 32'd0);
        step("run2_pc4",     1, 2'b00, 0, 32'h0,       32'h0,        0, 1, 32'h0000_0004, 1, 0, 0, 32'd0);

        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
